// File: rtl/spi_sram_pkg.sv
// Shared SPI SRAM command codes, field widths and master state encoding.
package spi_sram_pkg;

  localparam logic [7:0] SPI_CMD_READ  = 8'h03;
  localparam logic [7:0] SPI_CMD_WRITE = 8'h02;

  localparam int SPI_CMD_BITS  = 8;
  localparam int SPI_ADDR_BITS = 24;
  localparam int SPI_DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DATA,
    GAP
  } spi_mst_state_t;

endpackage

// File: rtl/spi_sram_master_sck_gen.sv
// sck divider: CLK_DIV clk cycles per half-period, idles low, restarts in low phase on clr.
// sample_stb marks the last high cycle (sck falls after it); fall_stb marks the first low cycle.
module spi_sck_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic sck,
  output logic fall_stb,
  output logic sample_stb
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt;
  logic          last;

  assign last       = (cnt == CW'(CLK_DIV - 1));
  assign sample_stb = en && sck && last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      sck      <= 1'b0;
      fall_stb <= 1'b0;
    end else begin
      fall_stb <= sample_stb;
      if (clr) begin
        cnt <= '0;
        sck <= 1'b0;
      end else if (en) begin
        if (last) begin
          cnt <= '0;
          sck <= ~sck;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/spi_sram_master.sv
// SPI mode-0 master turning byte requests into READ/WRITE SRAM frames; same-direction
// sequential requests presented in the end-of-byte window extend the open frame.
module spi_sram_master
  import spi_sram_pkg::*;
#(
  parameter int CLK_DIV = 2,
  parameter int CS_GAP  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [23:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        spi_cs_n,
  output logic        spi_sck,
  output logic        spi_mosi,
  input  logic        spi_miso
);

  localparam int GW = $clog2(CS_GAP + 1);

  spi_mst_state_t state, state_nxt;

  logic          wr_q;
  logic [23:0]   addr_q;
  logic [7:0]    wdata_q;
  logic [6:0]    rx_q;
  logic [7:0]    cmd_byte;
  logic [4:0]    bit_cnt;
  logic [4:0]    bit_nxt;
  logic [GW-1:0] gap_cnt;
  logic          sck_en;
  logic          fall_stb;
  logic          sample_stb;
  logic          accept;
  logic          burst_ok;
  logic          burst_acc;
  logic          window;
  logic          last_bit;

  assign cmd_byte = wr_q ? SPI_CMD_WRITE : SPI_CMD_READ;
  assign bit_nxt  = bit_cnt - 5'd1;
  assign last_bit = sample_stb && (bit_cnt == 5'd0);

  spi_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck_gen (
    .clk        (clk),
    .rst        (rst),
    .en         (sck_en),
    .clr        (accept),
    .sck        (spi_sck),
    .fall_stb   (fall_stb),
    .sample_stb (sample_stb)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // The burst window is the sck-falling cycle that carries the completion pulse.
  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    accept    = 1'b0;
    burst_acc = 1'b0;
    sck_en    = 1'b0;
    burst_ok  = req_valid && (req_wr == wr_q) && (req_addr == addr_q + 24'd1);
    window    = (state == DATA) && fall_stb && rsp_valid;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept    = 1'b1;
          state_nxt = CMD;
        end
      end
      CMD: begin
        sck_en = 1'b1;
        if (last_bit) state_nxt = ADDR;
      end
      ADDR: begin
        sck_en = 1'b1;
        if (last_bit) state_nxt = DATA;
      end
      DATA: begin
        if (window) begin
          if (burst_ok) begin
            req_ready = 1'b1;
            burst_acc = 1'b1;
            sck_en    = 1'b1;
          end else begin
            state_nxt = GAP;
          end
        end else begin
          sck_en = 1'b1;
        end
      end
      GAP: begin
        if (gap_cnt == '0) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rx_q      <= '0;
      bit_cnt   <= '0;
      gap_cnt   <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      spi_cs_n  <= 1'b1;
      spi_mosi  <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      if (accept) begin
        wr_q     <= req_wr;
        addr_q   <= req_addr;
        wdata_q  <= req_wdata;
        bit_cnt  <= 5'(SPI_CMD_BITS - 1);
        spi_cs_n <= 1'b0;
        spi_mosi <= req_wr ? SPI_CMD_WRITE[7] : SPI_CMD_READ[7];
      end else if (window) begin
        if (burst_acc) begin
          addr_q   <= req_addr;
          wdata_q  <= req_wdata;
          bit_cnt  <= 5'(SPI_DATA_BITS - 1);
          spi_mosi <= req_wr & req_wdata[7];
        end else begin
          spi_cs_n <= 1'b1;
          spi_mosi <= 1'b0;
          gap_cnt  <= GW'(CS_GAP - 1);
        end
      end else if (state == GAP) begin
        if (gap_cnt != '0) gap_cnt <= gap_cnt - 1'b1;
      end else if (sample_stb) begin
        // Next bit goes out on the same edge that drops sck.
        case (state)
          CMD: begin
            if (bit_cnt == 5'd0) begin
              bit_cnt  <= 5'(SPI_ADDR_BITS - 1);
              spi_mosi <= addr_q[SPI_ADDR_BITS-1];
            end else begin
              bit_cnt  <= bit_nxt;
              spi_mosi <= cmd_byte[bit_nxt[2:0]];
            end
          end
          ADDR: begin
            if (bit_cnt == 5'd0) begin
              bit_cnt  <= 5'(SPI_DATA_BITS - 1);
              spi_mosi <= wr_q & wdata_q[SPI_DATA_BITS-1];
            end else begin
              bit_cnt  <= bit_nxt;
              spi_mosi <= addr_q[bit_nxt];
            end
          end
          DATA: begin
            rx_q <= {rx_q[5:0], spi_miso};
            if (bit_cnt == 5'd0) begin
              rsp_valid <= 1'b1;
              spi_mosi  <= 1'b0;
              if (!wr_q) rsp_rdata <= {rx_q, spi_miso};
            end else begin
              bit_cnt  <= bit_nxt;
              spi_mosi <= wr_q & wdata_q[bit_nxt[2:0]];
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_sram_master.sv
// Randomized and directed bench for spi_sram_master with an SPI SRAM slave model,
// an arithmetic timing/memory reference model and a response scoreboard.
module tb_spi_sram_master;

  localparam int D = 2;
  localparam int G = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_wr = 1'b0;
  logic [23:0] req_addr = '0;
  logic [7:0]  req_wdata = '0;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        spi_cs_n;
  logic        spi_sck;
  logic        spi_mosi;
  logic        spi_miso = 1'b0;

  spi_sram_master #(.CLK_DIV(D), .CS_GAP(G)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_wr    (req_wr),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .spi_cs_n  (spi_cs_n),
    .spi_sck   (spi_sck),
    .spi_mosi  (spi_mosi),
    .spi_miso  (spi_miso)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          rsp_cyc;
    logic        wr;
    logic [23:0] addr;
    logic [7:0]  dat;
  } exp_t;

  typedef struct {
    logic [7:0]  cmd;
    logic [23:0] addr;
    logic [7:0]  mo;
  } slog_t;

  exp_t  sb[$];
  slog_t slog[$];

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
  endtask

  function automatic logic [7:0] def_byte(input logic [23:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5C;
  endfunction

  // Slave memory and reference-model memory are kept apart.
  logic [7:0] smem [logic [23:0]];
  logic [7:0] rmem [logic [23:0]];

  function automatic logic [7:0] smem_rd(input logic [23:0] a);
    return smem.exists(a) ? smem[a] : def_byte(a);
  endfunction

  function automatic logic [7:0] rmem_rd(input logic [23:0] a);
    return rmem.exists(a) ? rmem[a] : def_byte(a);
  endfunction

  // SPI SRAM slave model, evaluated away from the clk edge.
  int          s_bit = 0;
  int          s_frames = 0;
  logic        s_sck_p = 1'b0;
  logic        s_cs_p = 1'b1;
  logic [7:0]  s_cmd = '0;
  logic [23:0] s_addr = '0;
  logic [7:0]  s_mo = '0;
  logic [7:0]  s_mi = '0;

  initial begin
    forever begin
      @(negedge clk);
      if (s_cs_p && !spi_cs_n && !rst) s_frames++;
      if (rst || spi_cs_n) begin
        s_bit    = 0;
        spi_miso = 1'b0;
      end else if (spi_sck && !s_sck_p) begin
        if (s_bit < 8)       s_cmd  = {s_cmd[6:0], spi_mosi};
        else if (s_bit < 32) s_addr = {s_addr[22:0], spi_mosi};
        else                 s_mo   = {s_mo[6:0], spi_mosi};
        s_bit++;
        if (s_bit >= 40 && (s_bit % 8) == 0) begin
          if (s_cmd == 8'h02) smem[s_addr] = s_mo;
          slog.push_back('{cmd: s_cmd, addr: s_addr, mo: s_mo});
          s_addr = s_addr + 24'd1;
        end
      end else if (!spi_sck && s_sck_p && s_bit >= 32) begin
        if ((s_bit % 8) == 0) s_mi = (s_cmd == 8'h03) ? smem_rd(s_addr) : 8'h00;
        spi_miso = s_mi[7 - (s_bit % 8)];
      end
      s_sck_p = spi_sck;
      s_cs_p  = spi_cs_n;
    end
  end

  // Monitor: pops the scoreboard on every completion pulse.
  int hi_run = 0;
  bit had_frame = 0;

  initial begin
    exp_t  e;
    slog_t l;
    forever begin
      @(negedge clk);
      if (rst) begin
        hi_run    = 0;
        had_frame = 0;
      end else begin
        if (spi_cs_n) begin
          hi_run++;
        end else begin
          if (had_frame && hi_run > 0) chk("cs_n_gap_ge_CS_GAP", 32'(hi_run >= G), 32'd1);
          hi_run    = 0;
          had_frame = 1;
        end
        if (rsp_valid) begin
          if (sb.size() == 0) begin
            chk("rsp_with_empty_scoreboard", 32'(sb.size()), 32'd1);
          end else begin
            e = sb.pop_front();
            chk("rsp_cycle", 32'(cyc), 32'(e.rsp_cyc));
            if (!e.wr) chk("rsp_rdata", 32'(rsp_rdata), 32'(e.dat));
            if (slog.size() == 0) begin
              chk("slave_byte_missing", 32'(slog.size()), 32'd1);
            end else begin
              l = slog.pop_front();
              chk("mosi_cmd", 32'(l.cmd), e.wr ? 32'h02 : 32'h03);
              chk("mosi_addr", 32'(l.addr), 32'(e.addr));
              chk("mosi_data", 32'(l.mo), e.wr ? 32'(e.dat) : 32'h0);
            end
          end
        end
      end
    end
  end

  // Reference model: frame timing from the protocol arithmetic.
  int          m_rsp = -1000;
  logic        m_wr = 1'b0;
  logic [23:0] m_addr = '0;
  int          last_acc = 0;

  task automatic issue(input logic wr, input logic [23:0] addr, input logic [7:0] wd);
    int   p;
    int   exp_acc;
    int   exp_rsp;
    int   acc;
    int   i;
    bit   ok;
    logic [23:0] nxt;
    exp_t e;
    p   = cyc;
    nxt = m_addr + 24'd1;
    req_valid = 1'b1;
    req_wr    = wr;
    req_addr  = addr;
    req_wdata = wd;
    if (p <= m_rsp && wr == m_wr && addr == nxt) begin
      exp_acc = m_rsp;
      exp_rsp = m_rsp + 16 * D;
    end else begin
      exp_acc = (p > m_rsp + G + 1) ? p : m_rsp + G + 1;
      exp_rsp = exp_acc + 1 + 80 * D;
    end
    ok  = 0;
    acc = 0;
    i   = 0;
    while (!ok && i < 1000) begin
      @(negedge clk);
      ok  = req_ready;
      acc = cyc;
      @(posedge clk);
      #1;
      i++;
    end
    req_valid = 1'b0;
    chk("accept_within_budget", 32'(ok), 32'd1);
    if (ok) begin
      chk("accept_cycle", 32'(acc), 32'(exp_acc));
      e.rsp_cyc = exp_rsp;
      e.wr      = wr;
      e.addr    = addr;
      e.dat     = wr ? wd : rmem_rd(addr);
      sb.push_back(e);
      if (wr) rmem[addr] = wd;
      m_rsp    = exp_rsp;
      m_wr     = wr;
      m_addr   = addr;
      last_acc = acc;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int i;
    i = 0;
    while (sb.size() != 0 && i < 2000) begin
      @(posedge clk);
      i++;
    end
    #1;
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    sb.delete();
    idle(G + 3);
  endtask

  initial begin
    int          f0;
    bit          ok;
    logic        wr;
    logic        lw;
    logic [23:0] a;
    logic [23:0] la;
    logic [7:0]  wd;

    #1 rst = 1'b1;
    #2;
    chk("reset_cs_n", 32'(spi_cs_n), 32'd1);
    chk("reset_sck", 32'(spi_sck), 32'd0);
    chk("reset_mosi", 32'(spi_mosi), 32'd0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_rdata", 32'(rsp_rdata), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("reset_req_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;

    // Single write, then single read of preset data.
    issue(1'b1, 24'h012345, 8'h5A);
    drain();
    smem[24'h000010] = 8'hC3;
    rmem[24'h000010] = 8'hC3;
    issue(1'b0, 24'h000010, 8'h00);
    drain();
    chk("single_read_rdata_hold", 32'(rsp_rdata), 32'hC3);

    // Burst read across a byte-address carry.
    f0 = s_frames;
    issue(1'b0, 24'h0000FE, 8'h00);
    issue(1'b0, 24'h0000FF, 8'h00);
    issue(1'b0, 24'h000100, 8'h00);
    drain();
    chk("burst_read_frames", 32'(s_frames - f0), 32'd1);

    // Broken bursts: direction change, then address gap.
    f0 = s_frames;
    issue(1'b1, 24'h000010, 8'hA7);
    issue(1'b0, 24'h000011, 8'h00);
    drain();
    chk("broken_dir_frames", 32'(s_frames - f0), 32'd2);
    f0 = s_frames;
    issue(1'b1, 24'h000010, 8'h3C);
    issue(1'b1, 24'h000012, 8'h96);
    drain();
    chk("broken_addr_frames", 32'(s_frames - f0), 32'd2);

    // Wrap burst.
    f0 = s_frames;
    issue(1'b1, 24'hFFFFFF, 8'h11);
    issue(1'b1, 24'h000000, 8'h22);
    drain();
    chk("wrap_burst_frames", 32'(s_frames - f0), 32'd1);
    issue(1'b0, 24'hFFFFFF, 8'h00);
    issue(1'b0, 24'h000000, 8'h00);
    drain();

    // Randomized traffic around the wrap point.
    lw = 1'b0;
    la = '0;
    for (int n = 0; n < 40; n++) begin
      if (n > 0 && $urandom_range(0, 2) != 0) begin
        wr = lw;
        a  = la + 24'd1;
      end else begin
        wr = 1'($urandom_range(0, 1));
        a  = 24'hFFFFF8 + 24'($urandom_range(0, 15));
      end
      wd = 8'($urandom);
      if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 200));
      issue(wr, a, wd);
      lw = wr;
      la = a;
    end
    drain();

    // Reset while the address is being shifted.
    issue(1'b0, 24'h000200, 8'h00);
    ok = 0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      ok = (cyc >= last_acc + 64) && spi_sck;
    end
    chk("reached_addr_phase", 32'(ok), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("midframe_rst_cs_n", 32'(spi_cs_n), 32'd1);
    chk("midframe_rst_sck", 32'(spi_sck), 32'd0);
    chk("midframe_rst_mosi", 32'(spi_mosi), 32'd0);
    chk("midframe_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    sb.delete();
    slog.delete();
    m_rsp = -1000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_req_ready", 32'(req_ready), 32'd1);
    chk("post_rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    @(posedge clk);
    #1;
    issue(1'b0, 24'h000010, 8'h00);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_chk);
    $fatal(1);
  end

endmodule
